fetch_queue: RTL and testbench

//   Instruction fetch queue between the IF stage and the ID stage of the pipelined CPU.

---
 rtl/fetch_queue_if.sv | 43 ++++
 rtl/fetch_queue.sv | 82 ++++++++
 tb/tb_fetch_queue.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
//   Bundles the IF-side push port, the ID-side valid/ready port and the flush
//   control of the instruction fetch queue. Signal prefixes describe the
//   direction as seen from the queue (i_ = into the queue, o_ = out of it).
//
//   i_valid        IF presents a fetched instruction this cycle
//   i_pc, i_instr  PC and instruction word of that fetch
//   o_fetch_enable queue not full; drives the IF stage Enable
//   i_flush        drop every buffered entry (redirect path)
//   o_valid        head entry available to ID
//   i_id_ready     ID consumes the head entry this cycle
//   o_pc, o_pc4    head PC and head PC + 4
//   o_instr        head instruction word
//   o_count        number of valid entries, 0..DEPTH
//
//   Modports: slave = the queue itself, master = the surrounding pipeline.
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int PTR_W = 2
);
    logic             i_valid;
    logic [31:0]      i_pc;
    logic [31:0]      i_instr;
    logic             o_fetch_enable;
    logic             i_flush;
    logic             o_valid;
    logic             i_id_ready;
    logic [31:0]      o_pc;
    logic [31:0]      o_pc4;
    logic [31:0]      o_instr;
    logic [PTR_W:0]   o_count;

    modport slave (
        input  i_valid, i_pc, i_instr, i_flush, i_id_ready,
        output o_fetch_enable, o_valid, o_pc, o_pc4, o_instr, o_count
    );

    modport master (
        output i_valid, i_pc, i_instr, i_flush, i_id_ready,
        input  o_fetch_enable, o_valid, o_pc, o_pc4, o_instr, o_count
    );
endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch queue between the IF and ID stages. Buffers up to DEPTH
//   {PC, Instr} pairs so a decode stall does not immediately stall fetch.
//   The oldest entry is presented to ID with a valid/ready handshake; there is
//   no bypass, so an entry written on edge N appears on the outputs after N.
//
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset, clears pointers, count and storage
//   fq       fetch_queue_if.slave bundle (push, pop, flush and head outputs)
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    fetch_queue_if.slave  fq
);
    localparam logic [PTR_W:0]   C_FULL    = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE = (PTR_W)'(1);

    logic [31:0]      r_pc    [DEPTH];
    logic [31:0]      r_instr [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);

    // Fetch_Enable depends only on the registered count, so a same-cycle pop
    // never reopens the queue combinationally; the push is refused while full.
    assign w_push = fq.i_valid & ~w_full & ~fq.i_flush;
    assign w_pop  = ~w_empty & fq.i_id_ready & ~fq.i_flush;

    assign fq.o_fetch_enable = ~w_full;
    assign fq.o_valid        = ~w_empty;
    assign fq.o_count        = r_count;

    // An empty queue presents a nop at PC 0 rather than stale storage.
    assign fq.o_pc    = w_empty ? 32'd0 : r_pc[r_rd_ptr];
    assign fq.o_instr = w_empty ? 32'd0 : r_instr[r_rd_ptr];
    assign fq.o_pc4   = w_empty ? 32'd0 : r_pc[r_rd_ptr] + 32'd4;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
            end
        end else if (fq.i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc[r_wr_ptr]    <= fq.i_pc;
                r_instr[r_wr_ptr] <= fq.i_instr;
                r_wr_ptr          <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//   Directed bench for fetch_queue. Each accepted push is appended to a
//   scoreboard queue; each pop removes the oldest entry, which must match the
//   head the DUT presents. Inputs change and outputs are sampled on the
//   falling edge, away from the rising active edge.
// ---------------------------------------------------------------------------
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic   clk;
    logic   rst_n;
    entry_t sb[$];
    int     testsRun;
    int     testsFailed;

    fetch_queue_if #(.PTR_W(PTR_W)) fqIf ();

    fetch_queue #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .fq      (fqIf)
    );

    // 10-time-unit clock; rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Compares every DUT output with what the scoreboard contents imply.
    task automatic checkState(input string step);
        checkOutput({step, " count"}, 32'(fqIf.o_count), 32'(sb.size()));
        checkOutput({step, " fetch_enable"}, 32'(fqIf.o_fetch_enable),
                    32'(sb.size() != DEPTH));
        checkOutput({step, " out_valid"}, 32'(fqIf.o_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            checkOutput({step, " out_pc"}, fqIf.o_pc, sb[0].pc);
            checkOutput({step, " out_pc4"}, fqIf.o_pc4, sb[0].pc + 32'd4);
            checkOutput({step, " out_instr"}, fqIf.o_instr, sb[0].instr);
        end else begin
            checkOutput({step, " empty_pc"}, fqIf.o_pc, 32'd0);
            checkOutput({step, " empty_pc4"}, fqIf.o_pc4, 32'd0);
            checkOutput({step, " empty_instr"}, fqIf.o_instr, 32'd0);
        end
    endtask

    // Drives one cycle from a falling edge: check current outputs, update the
    // scoreboard with what the queue should accept/consume, then clock.
    task automatic applyStimulus(input string step, input logic valid,
                                 input logic [31:0] pc, input logic [31:0] instr,
                                 input logic ready, input logic flush);
        bit     doPush;
        bit     doPop;
        entry_t e;
        fqIf.i_valid    = valid;
        fqIf.i_pc       = pc;
        fqIf.i_instr    = instr;
        fqIf.i_id_ready = ready;
        fqIf.i_flush    = flush;
        #1;
        checkState(step);
        doPush = valid && (sb.size() != DEPTH) && !flush;
        doPop  = (sb.size() != 0) && ready && !flush;
        if (flush) begin
            sb.delete();
        end else begin
            if (doPop) begin
                void'(sb.pop_front());
            end
            if (doPush) begin
                e.pc    = pc;
                e.instr = instr;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        testsRun        = 0;
        testsFailed     = 0;
        rst_n           = 1'b0;
        fqIf.i_valid    = 1'b0;
        fqIf.i_pc       = '0;
        fqIf.i_instr    = '0;
        fqIf.i_id_ready = 1'b0;
        fqIf.i_flush    = 1'b0;
        repeat (2) @(negedge clk);
        checkState("reset");
        rst_n = 1'b1;

        // Step 1: single push, one-cycle latency through the empty queue
        applyStimulus("s1_push", 1'b1, 32'h3000, 32'h2401_0001, 1'b0, 1'b0);
        applyStimulus("s1_hold", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus("s1_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Step 2: fill under decode stall, drop the fifth push, drain in order
        for (int i = 0; i < 5; i++) begin
            applyStimulus("s2_fill", 1'b1, 32'h3000 + 32'(4 * i), 32'h1000_0000 + 32'(i),
                          1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus("s2_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end

        // Step 3: steady stream across the pointer wrap
        for (int i = 0; i < 10; i++) begin
            applyStimulus("s3_stream", 1'b1, 32'h4000 + 32'(4 * i), 32'h2000_0000 + 32'(i),
                          1'b1, 1'b0);
        end
        applyStimulus("s3_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Step 4: flush with a concurrent push; that push must be absent
        for (int i = 0; i < 3; i++) begin
            applyStimulus("s4_fill", 1'b1, 32'h5000 + 32'(4 * i), 32'h3000_0000 + 32'(i),
                          1'b0, 1'b0);
        end
        applyStimulus("s4_flush", 1'b1, 32'h5555_5550, 32'hDEAD_BEEF, 1'b1, 1'b1);
        applyStimulus("s4_after", 1'b1, 32'h6000, 32'h3C01_0006, 1'b0, 1'b0);
        applyStimulus("s4_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Step 5: full queue with push and pop requested -> pop only
        for (int i = 0; i < 4; i++) begin
            applyStimulus("s5_fill", 1'b1, 32'h7000 + 32'(4 * i), 32'h4000_0000 + 32'(i),
                          1'b0, 1'b0);
        end
        applyStimulus("s5_full", 1'b1, 32'h7010, 32'h4000_0004, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("s5_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end

        // PC + 4 wraps modulo 2^32
        applyStimulus("pc4_wrap", 1'b1, 32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 1'b0);
        applyStimulus("pc4_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Step 6: asynchronous reset between edges with two entries queued
        applyStimulus("s6_fill", 1'b1, 32'h8000, 32'h5000_0000, 1'b0, 1'b0);
        applyStimulus("s6_fill", 1'b1, 32'h8004, 32'h5000_0001, 1'b0, 1'b0);
        fqIf.i_valid = 1'b0;
        checkOutput("s6_pre count", 32'(fqIf.o_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        checkState("s6_async");
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus("s6_after", 1'b1, 32'h9000, 32'h5000_0002, 1'b1, 1'b0);
        applyStimulus("s6_final", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        checkState("final");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
